// File: rtl/board_io_wrapper_n.sv
// -----------------------------------------------------------------------------
// board_io_wrapper_n
//   Board I/O front end between active-low pins and active-high core logic.
//
//   Input side : each active-low push-button pin goes through a
//                SYNC_STAGES-deep synchroniser and a debounce counter. The
//                debounced level is active-high. One-cycle pressed/released
//                pulses are raised in the same cycle the level changes.
//   Output side: each active-low LED pin is driven from a per-channel PWM
//                comparator. The duty value is shadowed once per PWM period.
//
// Ports
//   clock                 in   system clock; all logic on the rising edge
//   reset_n               in   asynchronous assert, active-low reset
//   push_button_n         in   [NUM_BUTTONS] raw active-low pins (async)
//   push_button           out  [NUM_BUTTONS] debounced level, 1 = pressed
//   push_button_pressed   out  [NUM_BUTTONS] 1-cycle pulse on debounced press
//   push_button_released  out  [NUM_BUTTONS] 1-cycle pulse on debounced release
//   led                   in   [NUM_LEDS] LED enable, 1 = on
//   led_duty              in   [NUM_LEDS*PWM_WIDTH] channel i at
//                              [i*PWM_WIDTH +: PWM_WIDTH]
//   led_n                 out  [NUM_LEDS] active-low LED pins, registered
// -----------------------------------------------------------------------------
module board_io_wrapper_n #(
  parameter int NUM_BUTTONS     = 2,
  parameter int NUM_LEDS        = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PWM_WIDTH       = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_BUTTONS-1:0]        push_button_n,
  output logic [NUM_BUTTONS-1:0]        push_button,
  output logic [NUM_BUTTONS-1:0]        push_button_pressed,
  output logic [NUM_BUTTONS-1:0]        push_button_released,
  input  logic [NUM_LEDS-1:0]           led,
  input  logic [NUM_LEDS*PWM_WIDTH-1:0] led_duty,
  output logic [NUM_LEDS-1:0]           led_n
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PWM_WIDTH-1:0] DUTY_FULL = {PWM_WIDTH{1'b1}};

  // ---------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------
  // Bit 0 of each chain is the first flop after the pin.
  // Bit SYNC_STAGES-1 is the metastability-safe output.
  logic [NUM_BUTTONS-1:0][SYNC_STAGES-1:0] r_sync;
  logic [NUM_BUTTONS-1:0][CNT_W-1:0]       r_db_cnt;
  logic [NUM_BUTTONS-1:0]                  r_pb;
  logic [NUM_BUTTONS-1:0]                  r_pressed;
  logic [NUM_BUTTONS-1:0]                  r_released;
  logic [NUM_BUTTONS-1:0]                  w_raw;

  always_comb begin
    w_raw = '0;
    for (int b = 0; b < NUM_BUTTONS; b++) begin
      w_raw[b] = ~r_sync[b][SYNC_STAGES-1];
    end
  end

  // Synchroniser flops reset to 1, which is the released level of the pin.
  // This prevents a pressed pulse from appearing straight out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '1;
    end else begin
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        r_sync[b] <= {r_sync[b][SYNC_STAGES-2:0], push_button_n[b]};
      end
    end
  end

  // The counter runs only while the synchronised level differs from the
  // accepted level. Any agreement clears it, so a bounce restarts the count.
  // The counter is cleared on the accepting edge and never passes CNT_LAST,
  // so it cannot wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_db_cnt   <= '0;
      r_pb       <= '0;
      r_pressed  <= '0;
      r_released <= '0;
    end else begin
      r_pressed  <= '0;
      r_released <= '0;
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        if (w_raw[b] != r_pb[b]) begin
          if (r_db_cnt[b] == CNT_LAST) begin
            r_pb[b]       <= w_raw[b];
            r_db_cnt[b]   <= '0;
            r_pressed[b]  <= w_raw[b];
            r_released[b] <= ~w_raw[b];
          end else begin
            r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
          end
        end else begin
          r_db_cnt[b] <= '0;
        end
      end
    end
  end

  assign push_button          = r_pb;
  assign push_button_pressed  = r_pressed;
  assign push_button_released = r_released;

  // ---------------------------------------------------------------------------
  // Output path
  // ---------------------------------------------------------------------------
  logic [PWM_WIDTH-1:0]                r_pwm_cnt;
  logic [NUM_LEDS-1:0][PWM_WIDTH-1:0]  r_shadow;
  logic [NUM_LEDS-1:0]                 r_led_n;
  logic [NUM_LEDS-1:0]                 w_on;

  // The free-running counter wraps naturally at 2^PWM_WIDTH.
  // The shadows are the same layout as led_duty, so they load as one vector.
  // Loading only at count 0 means a duty change made mid-period cannot
  // stretch or cut short the pulse that is already running.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
      r_shadow  <= '1;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_pwm_cnt == '0) begin
        r_shadow <= led_duty;
      end
    end
  end

  // An all-ones duty is forced to 100% on. A plain "cnt < duty" compare would
  // leave the LED off for one cycle of every period.
  always_comb begin
    w_on = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      w_on[i] = led[i] & ((r_shadow[i] == DUTY_FULL) | (r_pwm_cnt < r_shadow[i]));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_led_n <= '1;
    end else begin
      r_led_n <= ~w_on;
    end
  end

  assign led_n = r_led_n;

endmodule

// File: tb/tb_board_io_wrapper_n.sv
module tb_board_io_wrapper_n;

  localparam int NB    = 2;
  localparam int NL    = 3;
  localparam int SS    = 2;
  localparam int DB    = 4;
  localparam int PW    = 4;
  localparam int OBS_W = 3 * NB + NL;
  localparam int PER   = 1 << PW;

  // ---------------------------------------------------------------------------
  // Clock / reset, DUT
  // ---------------------------------------------------------------------------
  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [NB-1:0]    push_button_n = '1;
  logic [NB-1:0]    push_button;
  logic [NB-1:0]    push_button_pressed;
  logic [NB-1:0]    push_button_released;
  logic [NL-1:0]    led = '0;
  logic [NL*PW-1:0] led_duty = '0;
  logic [NL-1:0]    led_n;

  always #5 clock = ~clock;

  board_io_wrapper_n #(
    .NUM_BUTTONS(NB), .NUM_LEDS(NL), .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DB), .PWM_WIDTH(PW)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .push_button_n(push_button_n),
    .push_button(push_button),
    .push_button_pressed(push_button_pressed),
    .push_button_released(push_button_released),
    .led(led),
    .led_duty(led_duty),
    .led_n(led_n)
  );

  int checks = 0;
  int errors = 0;
  int press_cnt [NB];
  int rel_cnt   [NB];

  // ---------------------------------------------------------------------------
  // Reference model.
  // Pins are seen SS cycles late. A level change is accepted once the seen
  // level has disagreed for DB consecutive cycles. The PWM is a modulo-PER
  // counter with a duty snapshot taken at count 0.
  // ---------------------------------------------------------------------------
  logic [OBS_W-1:0] exp_q[$];
  logic             m_pipe [NB][SS];
  logic [NB-1:0]    m_pb = '0;
  logic [NB-1:0]    m_pr = '0;
  logic [NB-1:0]    m_rl = '0;
  logic [NL-1:0]    m_ln = '1;
  int               m_diff_start [NB];
  int               m_cyc = 0;
  int               m_cnt = 0;
  int               m_shadow [NL];

  always @(posedge clock) begin : model
    logic raw;
    bit   duty_on;
    if (!reset_n) begin
      for (int b = 0; b < NB; b++) begin
        for (int s = 0; s < SS; s++) m_pipe[b][s] = 1'b1;
        m_diff_start[b] = -1;
      end
      m_pb  = '0;
      m_pr  = '0;
      m_rl  = '0;
      m_ln  = '1;
      m_cnt = 0;
      for (int i = 0; i < NL; i++) m_shadow[i] = PER - 1;
    end else begin
      m_cyc++;
      m_pr = '0;
      m_rl = '0;
      for (int b = 0; b < NB; b++) begin
        raw = ~m_pipe[b][SS-1];
        if (raw == m_pb[b]) begin
          m_diff_start[b] = -1;
        end else begin
          if (m_diff_start[b] < 0) m_diff_start[b] = m_cyc;
          if (m_cyc - m_diff_start[b] >= DB - 1) begin
            m_pb[b] = raw;
            m_pr[b] = raw;
            m_rl[b] = ~raw;
            m_diff_start[b] = -1;
          end
        end
        for (int s = SS - 1; s > 0; s--) m_pipe[b][s] = m_pipe[b][s-1];
        m_pipe[b][0] = push_button_n[b];
      end
      for (int i = 0; i < NL; i++) begin
        duty_on = (m_shadow[i] == PER - 1) || (m_cnt < m_shadow[i]);
        m_ln[i] = !(led[i] && duty_on);
      end
      if (m_cnt == 0) begin
        for (int i = 0; i < NL; i++) m_shadow[i] = int'(led_duty[i*PW +: PW]);
      end
      m_cnt = (m_cnt + 1) % PER;
    end
    exp_q.push_back({m_pb, m_pr, m_rl, m_ln});
  end

  // ---------------------------------------------------------------------------
  // Monitor: one observation per clock, compared against the queue.
  // ---------------------------------------------------------------------------
  always @(posedge clock) begin : monitor
    logic [OBS_W-1:0] exp_v;
    logic [OBS_W-1:0] act_v;
    #1;
    act_v = {push_button, push_button_pressed, push_button_released, led_n};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty t=%0t actual=%b required=queued entry", $time, act_v);
    end else begin
      exp_v = exp_q.pop_front();
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL scoreboard t=%0t actual=%b required=%b (pb,pr,rl,led_n)",
                 $time, act_v, exp_v);
      end
    end
    for (int b = 0; b < NB; b++) begin
      if (push_button_pressed[b] === 1'b1)  press_cnt[b]++;
      if (push_button_released[b] === 1'b1) rel_cnt[b]++;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver / helper tasks
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Returns the number of rising edges until push_button[b] == val, or -1.
  task automatic measure(input int b, input logic val, output int k);
    k = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (push_button[b] === val) begin
        k = n;
        break;
      end
    end
  endtask

  task automatic wait_cnt(input int c);
    for (int n = 0; n < 3 * PER; n++) begin
      if (m_cnt == c) break;
      @(negedge clock);
    end
  endtask

  // Counts cycles where led_n is low over the next `edges` rising edges.
  task automatic count_lows(input int edges, output int l0, output int l1, output int l2);
    l0 = 0;
    l1 = 0;
    l2 = 0;
    for (int n = 0; n < edges; n++) begin
      @(posedge clock);
      #1;
      if (led_n[0] === 1'b0) l0++;
      if (led_n[1] === 1'b0) l1++;
      if (led_n[2] === 1'b0) l2++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    int k, p0, r0, l0, l1, l2;
    int hold [NB];
    for (int b = 0; b < NB; b++) begin
      press_cnt[b] = 0;
      rel_cnt[b]   = 0;
    end

    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Idle after reset.
    repeat (20) @(negedge clock);
    check("idle_push_button", int'(push_button), 0);
    check("idle_led_n", int'(led_n), 7);
    check("idle_pulses", press_cnt[0] + press_cnt[1] + rel_cnt[0] + rel_cnt[1], 0);

    // Clean press on button 0.
    p0 = press_cnt[0];
    push_button_n[0] = 1'b0;
    measure(0, 1'b1, k);
    check("clean_press_latency", k, SS + DB);
    repeat (3) @(negedge clock);
    check("clean_press_pulses", press_cnt[0] - p0, 1);
    check("clean_press_btn1_idle", int'(push_button[1]) + press_cnt[1], 0);
    r0 = rel_cnt[0];
    push_button_n[0] = 1'b1;
    measure(0, 1'b0, k);
    check("clean_release_latency", k, SS + DB);
    repeat (3) @(negedge clock);
    check("clean_release_pulses", rel_cnt[0] - r0, 1);

    // Bounce: low 3, high 1, then low 10.
    p0 = press_cnt[0];
    push_button_n[0] = 1'b0;
    repeat (3) @(negedge clock);
    push_button_n[0] = 1'b1;
    @(negedge clock);
    push_button_n[0] = 1'b0;
    measure(0, 1'b1, k);
    check("bounce_press_latency", k, SS + DB);
    repeat (4) @(negedge clock);
    check("bounce_press_pulses", press_cnt[0] - p0, 1);
    push_button_n[0] = 1'b1;
    repeat (12) @(negedge clock);

    // PWM: ch2 full, ch1 duty 4, ch0 duty 0.
    led = 3'b111;
    led_duty = {4'hF, 4'h4, 4'h0};
    repeat (2 * PER) @(negedge clock);
    wait_cnt(1);
    count_lows(PER, l0, l1, l2);
    check("pwm_ch0_duty0_lows", l0, 0);
    check("pwm_ch1_duty4_lows", l1, 4);
    check("pwm_ch2_full_lows", l2, PER);

    // Mid-period duty change on ch1 (4 -> 8) at count 6.
    @(negedge clock);
    wait_cnt(6);
    led_duty[PW +: PW] = 4'h8;
    count_lows(PER - 6, l0, l1, l2);
    check("pwm_midperiod_no_glitch", l1, 0);
    @(negedge clock);
    wait_cnt(1);
    count_lows(PER, l0, l1, l2);
    check("pwm_next_period_duty8", l1, 8);

    // Randomised phase: bouncing pins, random enables and duties.
    for (int b = 0; b < NB; b++) hold[b] = $urandom_range(1, 10);
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      for (int b = 0; b < NB; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          push_button_n[b] = ~push_button_n[b];
          hold[b] = $urandom_range(1, 10);
        end
      end
      if ($urandom_range(0, 19) == 0) led = NL'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) led_duty = (NL*PW)'($urandom);
    end
    push_button_n = '1;
    repeat (15) @(negedge clock);
    check("random_settled_level", int'(push_button), 0);

    // Reset while button 0 is held and the PWM is running.
    led = 3'b111;
    led_duty = {4'hF, 4'h4, 4'h0};
    push_button_n[0] = 1'b0;
    repeat (20) @(negedge clock);
    check("held_before_reset", int'(push_button[0]), 1);
    reset_n = 1'b0;
    #1;
    check("reset_async_push_button", int'(push_button), 0);
    check("reset_async_pulses", int'(push_button_pressed) + int'(push_button_released), 0);
    check("reset_async_led_n", int'(led_n), 7);
    repeat (3) @(negedge clock);
    p0 = press_cnt[0];
    reset_n = 1'b1;
    measure(0, 1'b1, k);
    check("post_reset_press_latency", k, SS + DB);
    repeat (4) @(negedge clock);
    check("post_reset_press_pulses", press_cnt[0] - p0, 1);

    push_button_n = '1;
    repeat (20) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
